// File: rtl/fsm_periph_pkg.sv
// ---------------------------------------------------------------------------
// fsm_periph_pkg
//   Shared constants for the 16-bit peripheral link (dado/send/ack).
//   - SEND_* : request codes driven on send
//   - ACK_*  : response codes sampled on ack
//   - tx_state_t : initiator FSM state encoding
// ---------------------------------------------------------------------------
package fsm_periph_pkg;

  localparam int DATA_W_DEFAULT = 16;

  localparam logic [1:0] SEND_IDLE = 2'b00;
  localparam logic [1:0] SEND_REQ  = 2'b01;
  localparam logic [1:0] ACK_IDLE  = 2'b00;
  localparam logic [1:0] ACK_OK    = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    REL  = 2'b10
  } tx_state_t;

endpackage

// File: rtl/fsm_tx_fifo.sv
// ---------------------------------------------------------------------------
// fsm_tx_fifo
//   Synchronous word buffer between the core write port and the link FSM.
//   Ports:
//     clk, rst        clock, asynchronous active-low reset (empties FIFO)
//     push, wr_data   write request and word; ignored while full
//     pop, rd_data    read request and head word (rd_data valid when !empty)
//     full, empty     registered-count status
//     count           number of buffered words
//   FIFO_DEPTH must be a power of two so the pointers wrap on their own.
// ---------------------------------------------------------------------------
module fsm_tx_fifo
  import fsm_periph_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          pop,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fsm_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end

  assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fsm_processador_tx.sv
// ---------------------------------------------------------------------------
// fsm_processador_tx
//   Processor-side initiator for the peripheral link. Words written by the
//   core are buffered and sent one at a time with a 4-phase handshake:
//   send=01 with dado held, wait ack=01, send=00, wait ack=00.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | send=00; pops the FIFO head into dado when a word is waiting
//   REQ   | send=01, dado held; waits for ack==01 (00/10/11 keep waiting)
//   REL   | send=00, dado held; waits for ack==00, then counts the word
//
//   Ports:
//     clk, rst              clock, asynchronous active-low reset
//     wr_valid/wr_data      core write offer
//     wr_ready              not-full (from registered count only)
//     dado, send            registered link outputs
//     ack                   peripheral response
//     busy                  FIFO non-empty or FSM not in IDLE
//     sent_count            completed transfers, wraps at 255
//     timeout_err           one-cycle abort pulse (FSM_TX_TIMEOUT_EN only)
//
//   Build option FSM_TX_TIMEOUT_EN: abort a handshake phase after
//   TIMEOUT_CYCLES wait cycles, dropping the word.
// ---------------------------------------------------------------------------
module fsm_processador_tx
  import fsm_periph_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] dado,
  output logic [1:0]        send,
  input  logic [1:0]        ack,
  output logic              busy,
`ifdef FSM_TX_TIMEOUT_EN
  output logic [7:0]        sent_count,
  output logic              timeout_err
`else
  output logic [7:0]        sent_count
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_pop;
  logic              fifo_push;
  logic              ack_seen;
  logic              rel_seen;
  logic              abort;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fsm_processador_tx: TIMEOUT_CYCLES must be at least 1");
  end

  // A pop in the same cycle never frees a slot for a write while full,
  // because wr_ready looks only at the registered count.
  assign wr_ready  = !fifo_full;
  assign fifo_push = wr_valid && wr_ready;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign ack_seen  = (state == REQ) && (ack == ACK_OK);
  assign rel_seen  = (state == REL) && (ack == ACK_IDLE);

  fsm_tx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef FSM_TX_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_cnt;

  // The counter shows k after the k-th edge spent in a phase, so the abort
  // fires on the edge that would make it reach TIMEOUT_CYCLES. A normal
  // handshake completion on that same edge takes priority.
  assign abort = (state != IDLE) && !ack_seen && !rel_seen &&
                 (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= abort;
      if (state == IDLE || ack_seen || rel_seen || abort) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      dado       <= '0;
      send       <= SEND_IDLE;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            dado  <= fifo_head;
            send  <= SEND_REQ;
            state <= REQ;
          end
        end
        REQ: begin
          if (ack_seen) begin
            send  <= SEND_IDLE;
            state <= REL;
          end else if (abort) begin
            send  <= SEND_IDLE;
            state <= IDLE;
          end
        end
        REL: begin
          if (rel_seen) begin
            sent_count <= sent_count + 8'd1;
            state      <= IDLE;
          end else if (abort) begin
            state <= IDLE;
          end
        end
        default: begin
          send  <= SEND_IDLE;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_processador_tx.sv
// ---------------------------------------------------------------------------
// tb_fsm_processador_tx
//   Directed bench for fsm_processador_tx. The peripheral model returns
//   send as ack one registered cycle later; the bench can override ack with
//   a forced value. Inputs change and outputs are sampled on negedge.
// ---------------------------------------------------------------------------
module tb_fsm_processador_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [15:0] dado;
  logic [1:0]  send;
  logic [1:0]  ack;
  logic        busy;
  logic [7:0]  sent_count;
`ifdef FSM_TX_TIMEOUT_EN
  logic        timeout_err;
`endif

  logic [1:0]  ack_q;
  logic        ack_force_en;
  logic [1:0]  ack_force;

  int n_vec = 0;
  int n_err = 0;

  fsm_processador_tx #(
    .DATA_W         (16),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .dado        (dado),
    .send        (send),
    .ack         (ack),
    .busy        (busy),
`ifdef FSM_TX_TIMEOUT_EN
    .sent_count  (sent_count),
    .timeout_err (timeout_err)
`else
    .sent_count  (sent_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) ack_q <= 2'b00;
    else      ack_q <= send;
  end

  assign ack = ack_force_en ? ack_force : ack_q;

  task automatic check_vec(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic write_word(input logic [15:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    int exp_rdy [6] = '{1, 1, 1, 1, 1, 0};
    int n_rise;
    int last_rise;
    logic [1:0] prev_send;
    int sends;

    rst          = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    ack_force_en = 1'b0;
    ack_force    = 2'b00;

    // ---- reset state
    repeat (3) @(negedge clk);
    check_vec("rst_send",  send, 0);
    check_vec("rst_dado",  dado, 0);
    check_vec("rst_busy",  busy, 0);
    check_vec("rst_ready", wr_ready, 1);
    check_vec("rst_count", sent_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // ---- single word A5C3
    write_word(16'hA5C3);
    check_vec("w1_busy_t",  busy, 1);
    check_vec("w1_send_t",  send, 0);
    @(negedge clk);
    check_vec("w1_send_t1", send, 1);
    check_vec("w1_dado_t1", dado, 16'hA5C3);
    @(negedge clk);
    check_vec("w1_send_t2", send, 1);
    @(negedge clk);
    check_vec("w1_send_t3", send, 0);
    @(negedge clk);
    check_vec("w1_cnt_t4",  sent_count, 0);
    @(negedge clk);
    check_vec("w1_cnt_t5",  sent_count, 1);
    check_vec("w1_busy_t5", busy, 0);

    // ---- burst of 6 writes, depth 4: word 6 refused
    n_rise    = 0;
    last_rise = 0;
    prev_send = send;
    for (int i = 0; i < 40; i++) begin
      if (i < 6) begin
        wr_valid = 1'b1;
        wr_data  = 16'(i + 1);
        check_vec("burst_ready", wr_ready, exp_rdy[i]);
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      if (send == 2'b01 && prev_send == 2'b00) begin
        check_vec("burst_dado", dado, n_rise + 1);
        if (n_rise == 0) check_vec("burst_first", i, 1);
        else             check_vec("burst_gap", i - last_rise, 5);
        last_rise = i;
        n_rise++;
      end
      prev_send = send;
    end
    check_vec("burst_nwords", n_rise, 5);
    check_vec("burst_cnt",    sent_count, 6);
    check_vec("burst_busy",   busy, 0);

    // ---- ack held at 00 for 10 cycles during REQ
    ack_force_en = 1'b1;
    ack_force    = 2'b00;
    write_word(16'h1234);
    @(negedge clk);
    check_vec("hold_send0", send, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_vec("hold_send", send, 1);
      check_vec("hold_dado", dado, 16'h1234);
    end
    ack_force_en = 1'b0;
    @(negedge clk);
    check_vec("hold_rel_send", send, 0);
    repeat (2) @(negedge clk);
    check_vec("hold_cnt",  sent_count, 7);
    check_vec("hold_busy", busy, 0);

    // ---- ack=11 in REQ ignored, ack=10 in REL keeps waiting
    ack_force_en = 1'b1;
    ack_force    = 2'b11;
    write_word(16'hBEEF);
    @(negedge clk);
    check_vec("a11_send0", send, 1);
    check_vec("a11_dado",  dado, 16'hBEEF);
    repeat (3) begin
      @(negedge clk);
      check_vec("a11_send", send, 1);
    end
    ack_force = 2'b01;
    @(negedge clk);
    check_vec("a01_send", send, 0);
    ack_force = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check_vec("a10_send", send, 0);
      check_vec("a10_busy", busy, 1);
      check_vec("a10_cnt",  sent_count, 7);
    end
    ack_force = 2'b00;
    @(negedge clk);
    check_vec("a00_cnt",  sent_count, 8);
    check_vec("a00_busy", busy, 0);
    @(negedge clk);
    check_vec("a00_send", send, 0);
    ack_force_en = 1'b0;

    // ---- reset in REQ with 3 words buffered
    ack_force_en = 1'b1;
    ack_force    = 2'b00;
    wr_valid = 1'b1;
    wr_data  = 16'h0011; @(negedge clk);
    wr_data  = 16'h0022; @(negedge clk);
    wr_data  = 16'h0033; @(negedge clk);
    wr_data  = 16'h0044; @(negedge clk);
    wr_valid = 1'b0;
    check_vec("pre_rst_send", send, 1);
    check_vec("pre_rst_dado", dado, 16'h0011);
    check_vec("pre_rst_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check_vec("mid_rst_send",  send, 0);
    check_vec("mid_rst_busy",  busy, 0);
    check_vec("mid_rst_cnt",   sent_count, 0);
    check_vec("mid_rst_dado",  dado, 0);
    check_vec("mid_rst_ready", wr_ready, 1);
    @(negedge clk);
    rst          = 1'b1;
    ack_force_en = 1'b0;
    sends = 0;
    repeat (15) begin
      @(negedge clk);
      if (send != 2'b00) sends++;
    end
    check_vec("post_rst_sends", sends, 0);
    check_vec("post_rst_cnt",   sent_count, 0);
    check_vec("post_rst_busy",  busy, 0);

`ifdef FSM_TX_TIMEOUT_EN
    // ---- timeout with ack stuck at 00
    begin
      int pulses;
      int first_k;
      logic [1:0]  send16;
      logic [1:0]  send17;
      logic [15:0] dado17;
      int waited;
      pulses  = 0;
      first_k = -1;
      send16  = 2'b11;
      send17  = 2'b11;
      dado17  = '0;
      ack_force_en = 1'b1;
      ack_force    = 2'b00;
      wr_valid = 1'b1;
      wr_data  = 16'hAAAA; @(negedge clk);
      wr_data  = 16'hBBBB; @(negedge clk);
      wr_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (timeout_err) begin
          pulses++;
          if (first_k < 0) first_k = k;
        end
        if (k == 16) send16 = send;
        if (k == 17) begin
          send17 = send;
          dado17 = dado;
        end
      end
      check_vec("to_pulses", pulses, 1);
      check_vec("to_when",   first_k, 16);
      check_vec("to_send",   send16, 0);
      check_vec("to_cnt",    sent_count, 0);
      check_vec("to_next_send", send17, 1);
      check_vec("to_next_dado", dado17, 16'hBBBB);
      ack_force_en = 1'b0;
      waited = 0;
      while (sent_count != 8'd1 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check_vec("to_next_done", sent_count, 1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_processador_tx.md
Name: fsm_processador_tx

Overview:
- Processor-side initiator for the 16-bit peripheral link (dado/send/ack).
- Buffers words written by the core in a small FIFO.
- Transmits each word with a 4-phase handshake: send=01 with data held, wait ack=01, drop send to 00, wait ack=00.
- Sits between the processor datapath and peripheral 2; one instance per peripheral port.

Parameters:
- DATA_W, 16, width of dado and wr_data.
- FIFO_DEPTH, 4, word buffer entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 16, wait-cycle limit per handshake phase; used only with FSM_TX_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  core offers wr_data this cycle.
- wr_data  in  DATA_W  word to transmit.
- wr_ready  out  1  FIFO can accept; equals not-full.
- dado  out  DATA_W  data to peripheral; registered.
- send  out  2  request code to peripheral (00 idle, 01 request); registered.
- ack  in  2  peripheral response (00 idle, 01 acknowledged).
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- sent_count  out  8  completed transfers, wraps 255->0.
- timeout_err  out  1  one-cycle pulse on abort; present only with FSM_TX_TIMEOUT_EN.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; FIFO emptied.
  - dado=0, send=00, sent_count=0, timeout_err=0, busy=0, wr_ready=1.
  - Reset asserted mid-handshake drops send to 00 immediately; the in-flight word and all buffered words are lost.
- Write rule: a word is accepted at a posedge when wr_valid=1 and wr_ready=1. If wr_valid=1 while full, the write is ignored with no error. wr_ready depends only on the registered count, so a pop in the same cycle does not free a slot for a write while full. Push and pop in the same cycle when not full are both honoured.
- IDLE:
  - If FIFO non-empty: pop head, load dado, send<=01, go to REQ.
  - Otherwise send=00 and dado holds its last value.
- REQ:
  - send=01 and dado stable.
  - Stay until ack sampled ==01, then send<=00 and go to REL.
  - ack values 00, 10 and 11 all mean "keep waiting".
- REL:
  - send=00 and dado still held.
  - Stay until ack sampled ==00, then sent_count+1.
  - Then go to IDLE. The next word is launched from IDLE on the following edge.
- Latency (peripheral whose ack follows send by one registered cycle):
  - Word written at edge t: send=01 visible after edge t+1.
  - ack=01 after edge t+2; REL after edge t+3.
  - ack=00 after edge t+4; IDLE and count++ after edge t+5.
  - Next word's send=01 visible after edge t+6.
  - Steady-state throughput: 1 word per 5 cycles.
- send never takes values 10 or 11.
- busy is combinational from state and FIFO count.

Optional Feature:
- Macro: FSM_TX_TIMEOUT_EN.
- Enabled:
  - A wait counter clears on every state entry and increments each cycle spent in REQ or REL.
  - On the cycle the counter reaches TIMEOUT_CYCLES: send<=00, go to IDLE, pulse timeout_err for one cycle.
  - The word is dropped and sent_count is not incremented.
- Disabled: no counter, no timeout_err port; the FSM waits forever.

Decomposition:
- Package fsm_periph_pkg:
  - SEND_IDLE=2'b00, SEND_REQ=2'b01, ACK_IDLE=2'b00, ACK_OK=2'b01.
  - DATA_W default.
  - State enum tx_state_t {IDLE, REQ, REL}.
- Sub-module fsm_tx_fifo: synchronous FIFO with parameters DATA_W and FIFO_DEPTH, ports push/pop/full/empty/count, same asynchronous active-low reset.
- The FSM and counters live in the top module.

Test Plan:
- Single word 16'hA5C3 to empty FIFO, peripheral model acks one cycle after send:
  - send=01 and dado=A5C3 one cycle after the write.
  - send=00 after ack=01 is sampled.
  - sent_count=1 and busy=0 after ack=00.
- Burst of 6 writes (16'h0001..16'h0006) with FIFO_DEPTH=4:
  - wr_ready drops once 4 words are buffered; refused writes are not transmitted.
  - Accepted words appear on dado in order.
  - 5-cycle spacing between send rising edges.
- ack held at 00 for 10 cycles during REQ: send stays 01 and dado stable throughout; the transfer completes normally once ack=01.
- ack=2'b11 during REQ, then 01: 11 is ignored and the transfer completes. ack=2'b10 during REL: the FSM stays in REL until 00.
- rst pulsed low in REQ with 3 words buffered: send=00, busy=0, sent_count=0 immediately; no further transfers after release.
- FSM_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack stuck at 00:
  - timeout_err pulses once, 16 cycles after REQ entry.
  - send returns to 00 and sent_count is unchanged.
  - The next buffered word starts normally.
